// File: rtl/bert_mem_map_pkg.sv
// Shared memory-map definitions for the BERT activation/weight BRAM.
// Holds region base constants, Buffer_Select encodings, region/stride
// helpers, beats-per-tile constants and the writeback FSM state type.
package bert_mem_map_pkg;

  typedef enum logic [2:0] {
    BUF_W = 3'b000,
    BUF_B = 3'b001,
    BUF_I = 3'b010,
    BUF_Q = 3'b011,
    BUF_K = 3'b100,
    BUF_V = 3'b101
  } buf_sel_e;

  localparam int unsigned BASE_W = 0;
  localparam int unsigned BASE_B = 64;
  localparam int unsigned BASE_I = 112;
  localparam int unsigned BASE_Q = 0;

  localparam int unsigned BEATS_SMALL = 32;
  localparam int unsigned BEATS_LARGE = 512;

  localparam int unsigned TILE_PTR_W = 9;
  localparam int unsigned BEAT_CNT_W = 10;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WRITING,
    WB_DONE
  } wb_state_e;

  // BRAM words occupied by one full matrix.
  function automatic int unsigned region_words(input int unsigned cols,
                                               input int unsigned rows,
                                               input int unsigned nbits,
                                               input int unsigned dw);
    return (cols * rows * nbits) / dw;
  endfunction

  // BRAM words occupied by one logical matrix row.
  function automatic int unsigned row_stride(input int unsigned cols,
                                             input int unsigned nbits,
                                             input int unsigned dw);
    return (cols * nbits) / dw;
  endfunction

  // Base word address of the region selected by Buffer_Select.
  function automatic int unsigned region_base(input logic [2:0] sel,
                                              input int unsigned region);
    int unsigned b;
    b = 0;
    case (buf_sel_e'(sel))
      BUF_W:   b = BASE_W;
      BUF_B:   b = BASE_B;
      BUF_I:   b = BASE_I;
      BUF_Q:   b = BASE_Q;
      BUF_K:   b = region;
      BUF_V:   b = 2 * region;
      default: b = 0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/writeback_logic_gen_addr.sv
// wb_addr_gen: registered BRAM write stage.
// On each accepted beat it registers the write address (linear or
// column-stride placement), the beat data and a one-cycle write enable.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   accept         a beat is accepted this cycle
//   base           latched region base address
//   tile_ptr       current tile index
//   beat_cnt       index of the beat being accepted
//   n_beats        beats per tile (32 or 512)
//   transpose      1: column-stride placement, 0: linear
//   in_data        beat data
//   bram_addr/din/we  registered write command
module wb_addr_gen
  import bert_mem_map_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ROW_STRIDE = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [TILE_PTR_W-1:0] tile_ptr,
  input  logic [BEAT_CNT_W-1:0] beat_cnt,
  input  logic [BEAT_CNT_W-1:0] n_beats,
  input  logic                  transpose,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we
);

  logic [31:0] lin_addr;
  logic [31:0] tr_addr;
  logic [31:0] addr_full;

  // Computed at 32 bits and truncated: address arithmetic wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    lin_addr  = 32'(base) + 32'(tile_ptr) * 32'(n_beats) + 32'(beat_cnt);
    tr_addr   = 32'(base) + 32'(beat_cnt) * ROW_STRIDE + 32'(tile_ptr);
    addr_full = transpose ? tr_addr : lin_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr <= '0;
      bram_din  <= '0;
      bram_we   <= 1'b0;
    end else begin
      bram_we <= accept;
      if (accept) begin
        bram_addr <= addr_full[ADDR_WIDTH-1:0];
        bram_din  <= in_data;
      end
    end
  end

endmodule

// File: rtl/writeback_logic_gen.sv
// writeback_logic_gen: write-side address generator for the shared BRAM.
// Accepts result beats over valid/ready and issues registered BRAM writes
// into the region chosen by Buffer_Select, one tile per start_write,
// followed by a one-cycle write_done.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start_write         begin next tile (sampled only in IDLE)
//   reset_addr_counter  clear tile pointer
//   Buffer_Select       target region
//   Tiles_Control       1: 32 beats/tile, 0: 512 beats/tile
//   transpose_en        1: column-stride placement, 0: linear
//   in_data/in_valid/in_ready  beat handshake
//   bram_addr/bram_din/bram_we registered write command
//   write_done          one-cycle tile-end pulse
module writeback_logic_gen
  import bert_mem_map_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned DATA_WIDTH       = 256,
  parameter int unsigned ORIGINAL_COLUMNS = 768,
  parameter int unsigned ORIGINAL_ROWS    = 512,
  parameter int unsigned NUM_BITS         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_write,
  input  logic                  reset_addr_counter,
  input  logic [2:0]            Buffer_Select,
  input  logic                  Tiles_Control,
  input  logic                  transpose_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  write_done
);

  localparam int unsigned REGION =
    region_words(ORIGINAL_COLUMNS, ORIGINAL_ROWS, NUM_BITS, DATA_WIDTH);
  localparam int unsigned ROW_STRIDE =
    row_stride(ORIGINAL_COLUMNS, NUM_BITS, DATA_WIDTH);

  wb_state_e state, state_nxt;

  logic [TILE_PTR_W-1:0] tile_ptr;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [BEAT_CNT_W-1:0] n_beats;
  logic [ADDR_WIDTH-1:0] base;
  logic                  mode_tr;
  logic [31:0]           base_full;
  logic                  accept;
  logic                  last_beat;
  logic                  start_ok;

  assign base_full = region_base(Buffer_Select, REGION);
  assign start_ok  = (state == WB_IDLE) && start_write;
  assign in_ready  = (state == WB_WRITING) && (beat_cnt < n_beats);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_cnt == n_beats - BEAT_CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE:    if (start_write) state_nxt = WB_WRITING;
      WB_WRITING: if (last_beat)   state_nxt = WB_DONE;
      WB_DONE:    state_nxt = WB_IDLE;
      default:    state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WB_IDLE;
      tile_ptr   <= '0;
      beat_cnt   <= '0;
      n_beats    <= '0;
      base       <= '0;
      mode_tr    <= 1'b0;
      write_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      write_done <= last_beat;

      if (start_ok) begin
        base     <= base_full[ADDR_WIDTH-1:0];
        n_beats  <= Tiles_Control ? BEAT_CNT_W'(BEATS_SMALL) : BEAT_CNT_W'(BEATS_LARGE);
        mode_tr  <= transpose_en;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      end else if (state == WB_DONE) begin
        beat_cnt <= '0;
      end

      // A pointer clear outranks the end-of-tile advance.
      if (reset_addr_counter) begin
        tile_ptr <= '0;
      end else if (state == WB_DONE) begin
        tile_ptr <= tile_ptr + TILE_PTR_W'(1);
      end
    end
  end

  wb_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ROW_STRIDE (ROW_STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .base      (base),
    .tile_ptr  (tile_ptr),
    .beat_cnt  (beat_cnt),
    .n_beats   (n_beats),
    .transpose (mode_tr),
    .in_data   (in_data),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we)
  );

endmodule

// File: tb/tb_writeback_logic_gen.sv
// Self-checking bench for writeback_logic_gen: table of tile scenarios with
// hand-derived first addresses, random data and gaps, a queue-based
// reference of expected writes, and hand-written reset sequences.
module tb_writeback_logic_gen;

  localparam int AW = 16;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_write;
  logic          reset_addr_counter;
  logic [2:0]    Buffer_Select;
  logic          Tiles_Control;
  logic          transpose_en;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic          write_done;

  always #5 clk = ~clk;

  writeback_logic_gen #(
    .ADDR_WIDTH       (16),
    .DATA_WIDTH       (256),
    .ORIGINAL_COLUMNS (768),
    .ORIGINAL_ROWS    (512),
    .NUM_BITS         (8)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_write        (start_write),
    .reset_addr_counter (reset_addr_counter),
    .Buffer_Select      (Buffer_Select),
    .Tiles_Control      (Tiles_Control),
    .transpose_en       (transpose_en),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .bram_addr          (bram_addr),
    .bram_din           (bram_din),
    .bram_we            (bram_we),
    .write_done         (write_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
    bit            first;
  } wr_t;

  typedef struct {
    logic [2:0]  sel;
    bit          tc;
    bit          tr;
    bit          gaps;
    bit          rst_done;
    bit          mid_start;
    logic [31:0] exp_first;
  } tile_vec_t;

  wr_t          exp_q[$];
  int           checks    = 0;
  int           failures  = 0;
  int           done_seen = 0;
  int           exp_done  = 0;
  int unsigned  tp        = 0;
  logic [31:0]  first_addr;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned ref_base(input logic [2:0] sel);
    case (sel)
      3'd0: return 0;
      3'd1: return 64;
      3'd2: return 112;
      3'd3: return 0;
      3'd4: return 12288;
      3'd5: return 24576;
      default: return 0;
    endcase
  endfunction

  function automatic logic [AW-1:0] ref_addr(input logic [2:0] sel, input bit tr,
                                             input int unsigned n, input int unsigned k);
    logic [31:0] a;
    if (tr) a = ref_base(sel) + k * 24 + tp;
    else    a = ref_base(sel) + tp * n + k;
    return a[AW-1:0];
  endfunction

  // Every observed write must match the next expected write, in order.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_write: got write to %0h expected no write", bram_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bram_addr, e.addr);
        chk("wr_data", bram_din, e.data);
        chk("wr_done_align", write_done, e.last);
        if (e.first) first_addr = 32'(bram_addr);
      end
    end else if (write_done) begin
      checks++;
      failures++;
      $display("FAIL stray_done: got write_done=1 expected 0 (no write)");
    end
    if (write_done) done_seen++;
  end

  task automatic send_beat(input logic [DW-1:0] d, input wr_t e);
    int cnt;
    bit acc;
    cnt = 0;
    acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && cnt < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
      cnt++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got no in_ready in 100 cycles expected accept");
    end
  endtask

  task automatic start_tile(input logic [2:0] sel, input bit tc, input bit tr);
    Buffer_Select = sel;
    Tiles_Control = tc;
    transpose_en  = tr;
    start_write   = 1'b1;
    @(posedge clk);
    #1;
    start_write = 1'b0;
    chk("ready_after_start", in_ready, 1);
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_tile(input tile_vec_t v);
    int unsigned n;
    wr_t e;
    n = v.tc ? 32 : 512;
    first_addr = 32'hFFFF_FFFF;
    start_tile(v.sel, v.tc, v.tr);
    for (int unsigned k = 0; k < n; k++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      if (v.mid_start && k == 5) begin
        start_write   = 1'b1;
        Buffer_Select = 3'd5;
        transpose_en  = ~v.tr;
      end
      e.addr  = ref_addr(v.sel, v.tr, n, k);
      e.data  = rand_word();
      e.last  = (k == n - 1);
      e.first = (k == 0);
      send_beat(e.data, e);
      start_write   = 1'b0;
      Buffer_Select = v.sel;
      transpose_en  = v.tr;
    end
    chk("ready_in_done", in_ready, 0);
    reset_addr_counter = v.rst_done;
    @(posedge clk);
    #1;
    reset_addr_counter = 1'b0;
    exp_done++;
    tp = v.rst_done ? 0 : (tp + 1) % 512;
    chk("first_addr", first_addr, v.exp_first);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_we"},    bram_we,    0);
    chk({tag, "_addr"},  bram_addr,  0);
    chk({tag, "_din"},   bram_din,   0);
    chk({tag, "_done"},  write_done, 0);
    chk({tag, "_ready"}, in_ready,   0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected completion within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_vec_t vecs[7];
    wr_t e;
    tile_vec_t restart;

    //               sel   tc tr gp rd ms  first address
    vecs[0] = '{3'd0, 1, 0, 0, 0, 0, 32'd0};      // W, tile 0
    vecs[1] = '{3'd2, 0, 0, 0, 0, 0, 32'd624};    // I, tile 1, 512 beats
    vecs[2] = '{3'd4, 1, 1, 0, 0, 0, 32'd12290};  // K transposed, tile 2
    vecs[3] = '{3'd1, 1, 0, 1, 1, 0, 32'd160};    // b with gaps, ptr clear in DONE
    vecs[4] = '{3'd5, 1, 0, 0, 0, 0, 32'd24576};  // V restarts at tile 0
    vecs[5] = '{3'd3, 1, 1, 1, 0, 0, 32'd1};      // Q transposed with gaps, tile 1
    vecs[6] = '{3'd7, 1, 0, 0, 0, 1, 32'd64};     // unmapped select, stray start mid-tile

    rst_n              = 1'b0;
    start_write        = 1'b0;
    reset_addr_counter = 1'b0;
    Buffer_Select      = 3'd0;
    Tiles_Control      = 1'b1;
    transpose_en       = 1'b0;
    in_data            = '0;
    in_valid           = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) send_tile(vecs[i]);

    // Abandon a tile after ten accepted beats.
    start_tile(3'd0, 1'b1, 1'b0);
    for (int unsigned k = 0; k < 10; k++) begin
      e.addr  = ref_addr(3'd0, 1'b0, 32, k);
      e.data  = rand_word();
      e.last  = 1'b0;
      e.first = 1'b0;
      send_beat(e.data, e);
    end
    rst_n = 1'b0;
    exp_q.delete();
    tp = 0;
    @(negedge clk);
    chk_cleared("midtile_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    restart = '{3'd0, 1, 0, 0, 0, 0, 32'd0};
    send_tile(restart);

    repeat (4) @(posedge clk);
    #1;
    chk("done_count", 32'(done_seen), 32'(exp_done));
    chk("pending_writes", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
